uart_mmio_fifo: RTL

Memory-mapped UART bridge between the CPU data-memory stage and the UART core. It replaces the single-byte, unbuffered UART decode with parametrised TX/RX FIFOs, sticky error flags, occupancy counters and a level interrupt. The CPU sees a small register window; the UART side uses the existing ready/valid byte handshake.

---
 rtl/uart_mmio_fifo_pkg.sv | 22 ++
 rtl/uart_mmio_fifo_if.sv | 30 +++
 rtl/uart_mmio_fifo_sync_fifo.sv | 62 ++++++
 rtl/uart_mmio_fifo.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_mmio_fifo_pkg.sv
// Register map and bit positions shared by the UART MMIO bridge and its bench.
// No logic; offsets are byte offsets within the 32-byte register window.
package uart_mmio_pkg;

  typedef logic [4:0] reg_off_t;

  localparam reg_off_t REG_STATUS = 5'h00;
  localparam reg_off_t REG_RXDATA = 5'h04;
  localparam reg_off_t REG_TXDATA = 5'h08;
  localparam reg_off_t REG_COUNT  = 5'h0C;
  localparam reg_off_t REG_IRQEN  = 5'h10;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_RX_OVF       = 2;
  localparam int ST_TX_DROP      = 3;

  localparam int IE_RX_NOT_EMPTY = 0;
  localparam int IE_TX_EMPTY     = 1;
  localparam int IE_RX_OVF       = 2;

endpackage

// File: rtl/uart_mmio_fifo_if.sv
// CPU load/store window plus UART byte handshake, bundled for the bridge.
// master = CPU/UART side driving the bridge; slave = the bridge itself.
interface uart_mmio_fifo_if #(parameter int DATA_W = 8);

  logic              stall;
  logic [31:0]       addr;
  logic              re;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              hit;
  logic              irq;
  logic [DATA_W-1:0] uart_din;
  logic              uart_din_valid;
  logic              uart_din_ready;
  logic [DATA_W-1:0] uart_dout;
  logic              uart_dout_valid;
  logic              uart_dout_ready;

  modport master (
    output stall, addr, re, we, wdata, uart_din_ready, uart_dout, uart_dout_valid,
    input  rdata, hit, irq, uart_din, uart_din_valid, uart_dout_ready
  );

  modport slave (
    input  stall, addr, re, we, wdata, uart_din_ready, uart_dout, uart_dout_valid,
    output rdata, hit, irq, uart_din, uart_din_valid, uart_dout_ready
  );

endinterface

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; 1-cycle push-to-head latency.
// Push when full and pop when empty are silently ignored; no backpressure signal beyond full/empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage is not reset; emptiness is tracked purely by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// MMIO bridge between CPU load/store and UART bytes via TX/RX FIFOs; rdata and irq 1-cycle registered.
// TX waits on uart_din_ready; RX is always accepted and drops on full with a sticky overflow flag.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          CNT_W     = $clog2(((TX_DEPTH > RX_DEPTH) ? TX_DEPTH : RX_DEPTH) + 1)
) (
  input logic              clk,
  input logic              rst,
  uart_mmio_fifo_if.slave  bus
);

  localparam int TXC_W = $clog2(TX_DEPTH + 1);
  localparam int RXC_W = $clog2(RX_DEPTH + 1);

  logic [DATA_W-1:0] tx_head, rx_head;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TXC_W-1:0]  tx_count;
  logic [RXC_W-1:0]  rx_count;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              acc_wr, acc_rd;
  reg_off_t          off;

  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  irqen_q, irqen_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        tx_drop_q, tx_drop_d;
  logic        irq_q, irq_d;
  logic        unused_wdata;

  assign off          = bus.addr[4:0];
  assign bus.hit      = (bus.addr[31:5] == BASE_ADDR[31:5]);
  // Store wins over a simultaneous load, so acc_rd excludes we.
  assign acc_wr       = bus.hit && bus.we && !bus.stall;
  assign acc_rd       = bus.hit && bus.re && !bus.we && !bus.stall;
  assign unused_wdata = ^bus.wdata[31:DATA_W];

  assign tx_push = acc_wr && (off == REG_TXDATA);
  assign tx_pop  = bus.uart_din_valid && bus.uart_din_ready;
  assign rx_push = bus.uart_dout_valid;
  assign rx_pop  = acc_rd && (off == REG_RXDATA);

  assign bus.uart_din        = tx_head;
  assign bus.uart_din_valid  = !tx_empty;
  assign bus.uart_dout_ready = 1'b1;
  assign bus.rdata           = rdata_q;
  assign bus.irq             = irq_q;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.wdata[DATA_W-1:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(bus.uart_dout),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    rdata_d   = rdata_q;
    irqen_d   = irqen_q;
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;

    if (acc_wr && off == REG_STATUS) begin
      if (bus.wdata[ST_RX_OVF])  rx_ovf_d  = 1'b0;
      if (bus.wdata[ST_TX_DROP]) tx_drop_d = 1'b0;
    end
    if (acc_wr && off == REG_IRQEN) irqen_d = bus.wdata[2:0];
    // Sets are applied after clears so a same-cycle set wins.
    if (rx_push && rx_full) rx_ovf_d  = 1'b1;
    if (tx_push && tx_full) tx_drop_d = 1'b1;

    if (acc_rd) begin
      rdata_d = '0;
      case (off)
        REG_STATUS: begin
          rdata_d[ST_TX_NOT_FULL]  = !tx_full;
          rdata_d[ST_RX_NOT_EMPTY] = !rx_empty;
          rdata_d[ST_RX_OVF]       = rx_ovf_q;
          rdata_d[ST_TX_DROP]      = tx_drop_q;
        end
        REG_RXDATA: if (!rx_empty) rdata_d[DATA_W-1:0] = rx_head;
        REG_COUNT: begin
          rdata_d[CNT_W-1:0]  = CNT_W'(tx_count);
          rdata_d[16 +: CNT_W] = CNT_W'(rx_count);
        end
        REG_IRQEN: rdata_d[2:0] = irqen_q;
        default: rdata_d = '0;
      endcase
    end

    irq_d = (irqen_q[IE_RX_NOT_EMPTY] && !rx_empty) ||
            (irqen_q[IE_TX_EMPTY]     && tx_empty)  ||
            (irqen_q[IE_RX_OVF]       && rx_ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q   <= '0;
      irqen_q   <= '0;
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      irqen_q   <= irqen_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
      irq_q     <= irq_d;
    end
  end

endmodule
